// File: rtl/bus_arbiter.sv
// Central bus arbiter: one-hot grant, burst-bounded unlocked ownership, locked sequences, RETRY/SPLIT release.
// Optional macro ARB_ROUND_ROBIN_EN selects rotating-pointer winner selection; otherwise the lowest index wins.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_BURST   = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] HREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MW-1:0]          owner_d;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic                   lock_d;
  logic                   take;
  logic [MW-1:0]          take_idx;

  logic [NUM_MASTERS-1:0] own_oh, others, eff_lock;
  logic                   own_req, own_lock, release_bus;
  logic [MW:0]            win_any, win_oth;

`ifdef ARB_ROUND_ROBIN_EN
  logic [MW-1:0] ptr_q, ptr_d;

  // Search starts just after the pointer and wraps; the pointer itself is visited last.
  function automatic logic [MW:0] pick(input logic [NUM_MASTERS-1:0] cand, input logic [MW-1:0] ptr);
    logic [MW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (cand[idx]) r = {1'b1, MW'(idx)};
    end
    return r;
  endfunction

  assign win_any = pick(HREQ, ptr_q);
  assign win_oth = pick(others, ptr_q);
`else
  function automatic logic [MW:0] pick(input logic [NUM_MASTERS-1:0] cand);
    logic [MW:0] r;
    r = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cand[i]) r = {1'b1, MW'(i)};
    end
    return r;
  endfunction

  assign win_any = pick(HREQ);
  assign win_oth = pick(others);
`endif

  assign own_oh      = NUM_MASTERS'(1) << HMASTER;
  assign others      = HREQ & ~own_oh;
  assign eff_lock    = HLOCK & HREQ;
  assign own_req     = |(HREQ & own_oh);
  assign own_lock    = |(eff_lock & own_oh);
  assign release_bus = HREADY && ((HRESP == 2'b10) || (HRESP == 2'b11));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      HGRANT    <= '0;
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= MW'(NUM_MASTERS - 1);
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      HGRANT    <= gnt_d;
      HMASTER   <= owner_d;
      HMASTLOCK <= lock_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = HMASTER;
    take     = 1'b0;
    take_idx = win_any[MW-1:0];
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: take = win_any[MW];
      default: begin
        if (HREADY) begin
          // Release (owner dropped or RETRY/SPLIT) hands over directly, skipping IDLE when someone waits.
          if (release_bus || !own_req) begin
            take     = win_oth[MW];
            take_idx = win_oth[MW-1:0];
            if (!win_oth[MW]) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (state_q == LOCKED) begin
            if (!own_lock) state_d = OWNED;
            cnt_d = '0;
          end else if (own_lock) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else if (!win_oth[MW]) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(MAX_BURST - 1)) begin
            take     = 1'b1;
            take_idx = win_oth[MW-1:0];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
    if (take) begin
      state_d = |(eff_lock & (NUM_MASTERS'(1) << take_idx)) ? LOCKED : OWNED;
      owner_d = take_idx;
      cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_d   = take_idx;
`endif
    end
  end

  always_comb begin
    gnt_d  = '0;
    if (state_d != IDLE) gnt_d = NUM_MASTERS'(1) << owner_d;
    lock_d = (state_d == LOCKED);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter against an ownership-level reference model.
module tb_bus_arbiter;
  localparam int N  = 3;
  localparam int MB = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         CLK, RST;
  logic [N-1:0] HREQ, HLOCK;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, whether locked, beats held under contention.
  int m_owner, m_ptr, m_cnt;
  bit m_busy, m_lock;

  bus_arbiter #(.NUM_MASTERS(N), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST), .HREQ(HREQ), .HLOCK(HLOCK), .HREADY(HREADY),
    .HRESP(HRESP), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_ptr = N - 1; m_cnt = 0; m_busy = 0; m_lock = 0;
  endtask

  function automatic int pick_w(input logic [N-1:0] req, input int excl);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = RR ? (m_ptr + k) % N : k - 1;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_take(input int w, input logic [N-1:0] req, input logic [N-1:0] lk);
    if (w < 0) begin
      m_busy = 0; m_lock = 0; m_cnt = 0;
    end else begin
      m_owner = w; m_ptr = w; m_busy = 1; m_cnt = 0;
      m_lock = req[w] && lk[w];
    end
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lk,
                            input logic rdy, input logic [1:0] resp);
    bit own_req, own_lk, others;
    if (!m_busy) begin
      model_take(pick_w(req, -1), req, lk);
    end else if (rdy) begin
      own_req = req[m_owner];
      own_lk  = own_req && lk[m_owner];
      others  = pick_w(req, m_owner) >= 0;
      if (resp >= 2'd2 || !own_req) model_take(pick_w(req, m_owner), req, lk);
      else if (m_lock) begin m_lock = own_lk; m_cnt = 0; end
      else if (own_lk) begin m_lock = 1; m_cnt = 0; end
      else if (!others) m_cnt = 0;
      else if (m_cnt == MB - 1) model_take(pick_w(req, m_owner), req, lk);
      else m_cnt++;
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic rdy, input logic [1:0] resp);
    logic [N-1:0] eg;
    HREQ = req; HLOCK = lk; HREADY = rdy; HRESP = resp;
    @(posedge CLK);
    model_step(req, lk, rdy, resp);
    #1;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    chk("hgrant", 32'(HGRANT), 32'(eg));
    chk("hmaster", 32'(HMASTER), 32'(m_owner));
    chk("hmastlock", 32'(HMASTLOCK), 32'(m_lock));
    chk("onehot0", 32'($onehot0(HGRANT)), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_hgrant", 32'(HGRANT), 32'd0);
    chk("rst_hmaster", 32'(HMASTER), 32'd0);
    chk("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int rot_seq[4];
  logic [N-1:0] rq, lk;
  logic [1:0]   rs;

  initial begin
    if (RR) rot_seq = '{0, 1, 2, 0};
    else    rot_seq = '{0, 1, 0, 1};
    HREQ = '0; HLOCK = '0; HREADY = 1'b1; HRESP = 2'b00; RST = 1'b0;
    #2;
    do_reset();

    // First grant, then async reset while granted
    step(3'b010, 3'b000, 1'b1, 2'b00);
    chk("first_gnt", 32'(HGRANT), 32'b010);
    chk("first_mst", 32'(HMASTER), 32'd1);
    #2;
    do_reset();

    // Full contention: burst-bounded rotation
    for (int s = 0; s < 16; s++) begin
      step(3'b111, 3'b000, 1'b1, 2'b00);
      chk("rotation", 32'(HMASTER), 32'(rot_seq[s / 4]));
    end
    #2; do_reset();

    // Locked owner 2 holds through contention
    step(3'b100, 3'b100, 1'b1, 2'b00);
    for (int s = 0; s < 10; s++) step(3'b111, 3'b100, 1'b1, 2'b00);
    chk("lock_gnt", 32'(HGRANT), 32'b100);
    chk("lock_ml", 32'(HMASTLOCK), 32'd1);
    step(3'b011, 3'b000, 1'b1, 2'b00);
    chk("unlock_gnt", 32'(HGRANT), 32'b001);
    chk("unlock_ml", 32'(HMASTLOCK), 32'd0);
    #2; do_reset();

    // Wait states freeze ownership
    step(3'b001, 3'b000, 1'b1, 2'b00);
    for (int s = 0; s < 5; s++) step(3'b010, 3'b000, 1'b0, 2'b00);
    chk("wait_hold", 32'(HGRANT), 32'b001);
    step(3'b010, 3'b000, 1'b1, 2'b00);
    chk("wait_move", 32'(HGRANT), 32'b010);
    #2; do_reset();

    // SPLIT releases a locked owner
    step(3'b010, 3'b010, 1'b1, 2'b00);
    step(3'b011, 3'b010, 1'b1, 2'b11);
    chk("split_gnt", 32'(HGRANT), 32'b001);
    chk("split_ml", 32'(HMASTLOCK), 32'd0);
    #2; do_reset();
    step(3'b010, 3'b010, 1'b1, 2'b00);
    step(3'b010, 3'b010, 1'b1, 2'b11);
    chk("split_idle", 32'(HGRANT), 32'b000);
    #2; do_reset();

    // Lone requester never rotates
    for (int s = 0; s < 21; s++) step(3'b001, 3'b000, 1'b1, 2'b00);
    chk("solo_gnt", 32'(HGRANT), 32'b001);
    step(3'b000, 3'b000, 1'b1, 2'b00);
    chk("solo_idle", 32'(HGRANT), 32'b000);
    #2; do_reset();

    // Random traffic
    for (int s = 0; s < 2000; s++) begin
      rq = N'($urandom_range(0, 7));
      lk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      step(rq, lk, $urandom_range(0, 3) != 0, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
